branch_order_ctrl: RTL and testbench

- Tracks in-flight conditional branches between fetch and branch resolution.
- Records each branch's prediction, global-history snapshot and alternate PC at issue, and accepts out-of-order resolutions by tag.
- Retires branches in program order, emitting predictor-update pulses.
- On a mispredicted retire, sequences recovery: flush, fetch redirect, history restore, then a fixed quiet period before resuming.

---
 rtl/branch_order_ctrl.sv | 158 +++++++++++++++
 tb/tb_branch_order_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_order_ctrl.sv
// In-flight conditional branch tracker: records predictions at issue, accepts
// out-of-order resolutions by tag, retires in order and sequences mispredict recovery.
module branch_order_ctrl #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned HISTORY_BITS   = 8,
  parameter int unsigned RECOVER_CYCLES = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      issue_valid_i,
  output logic                      issue_ready_o,
  input  logic                      issue_pred_taken_i,
  input  logic [HISTORY_BITS-1:0]   issue_history_i,
  input  logic [31:0]               issue_alt_pc_i,
  output logic [$clog2(DEPTH)-1:0]  issue_tag_o,
  input  logic                      res_valid_i,
  output logic                      res_ready_o,
  input  logic [$clog2(DEPTH)-1:0]  res_tag_i,
  input  logic                      res_taken_i,
  output logic                      upd_valid_o,
  output logic                      upd_taken_o,
  output logic [HISTORY_BITS-1:0]   upd_history_o,
  output logic                      flush_o,
  output logic                      redirect_valid_o,
  output logic [31:0]               redirect_pc_o,
  output logic [HISTORY_BITS-1:0]   restore_history_o,
  output logic [$clog2(DEPTH):0]    inflight_o
);

  localparam int unsigned TW = $clog2(DEPTH);
  localparam int unsigned OW = TW + 1;
  localparam int unsigned CW = $clog2(RECOVER_CYCLES + 1);

  localparam logic [0:0] S_RUN     = 1'b0;
  localparam logic [0:0] S_RECOVER = 1'b1;

  logic [0:0]              state, state_d;
  logic [CW-1:0]           cnt, cnt_d;
  logic [TW-1:0]           head, tail;
  logic [DEPTH-1:0]        ent_valid, ent_resolved, ent_pred, ent_actual;
  logic [HISTORY_BITS-1:0] ent_hist [DEPTH];
  logic [31:0]             ent_alt  [DEPTH];

  logic full, issue_fire, res_fire, res_hit, retire, mispredict;

  // Handshake readiness comes only from registered state, never from a same-cycle retire.
  always_comb begin
    full          = (inflight_o == OW'(DEPTH));
    issue_ready_o = reset_n_i && (state == S_RUN) && !full;
    res_ready_o   = reset_n_i && (state == S_RUN);
    issue_tag_o   = tail;
    issue_fire    = issue_valid_i && issue_ready_o;
    res_fire      = res_valid_i && res_ready_o;
    res_hit       = res_fire && ent_valid[res_tag_i] && !ent_resolved[res_tag_i];
    retire        = (state == S_RUN) && ent_valid[head] && ent_resolved[head];
    mispredict    = retire && (ent_actual[head] != ent_pred[head]);
  end

  // Next-state logic: RUN, or RECOVER while the quiet-period counter drains.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      S_RUN: begin
        if (mispredict) begin
          state_d = S_RECOVER;
          cnt_d   = CW'(RECOVER_CYCLES);
        end
      end
      S_RECOVER: begin
        cnt_d = cnt - CW'(1);
        if (cnt == CW'(1)) state_d = S_RUN;
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Branch table; a mispredict wipes it and drops any same-cycle issue or resolution.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head         <= '0;
      tail         <= '0;
      inflight_o   <= '0;
      ent_valid    <= '0;
      ent_resolved <= '0;
      ent_pred     <= '0;
      ent_actual   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_hist[i] <= '0;
        ent_alt[i]  <= '0;
      end
    end else if (mispredict) begin
      head         <= '0;
      tail         <= '0;
      inflight_o   <= '0;
      ent_valid    <= '0;
      ent_resolved <= '0;
    end else begin
      if (retire) begin
        ent_valid[head]    <= 1'b0;
        ent_resolved[head] <= 1'b0;
        head               <= head + TW'(1);
      end
      if (res_hit) begin
        ent_resolved[res_tag_i] <= 1'b1;
        ent_actual[res_tag_i]   <= res_taken_i;
      end
      if (issue_fire) begin
        ent_valid[tail]    <= 1'b1;
        ent_resolved[tail] <= 1'b0;
        ent_pred[tail]     <= issue_pred_taken_i;
        ent_hist[tail]     <= issue_history_i;
        ent_alt[tail]      <= issue_alt_pc_i;
        tail               <= tail + TW'(1);
      end
      inflight_o <= inflight_o + OW'(issue_fire) - OW'(retire);
    end
  end

  // Registered retire and recovery outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      upd_valid_o       <= 1'b0;
      upd_taken_o       <= 1'b0;
      upd_history_o     <= '0;
      flush_o           <= 1'b0;
      redirect_valid_o  <= 1'b0;
      redirect_pc_o     <= '0;
      restore_history_o <= '0;
    end else begin
      upd_valid_o      <= retire;
      flush_o          <= mispredict;
      redirect_valid_o <= mispredict;
      if (retire) begin
        upd_taken_o   <= ent_actual[head];
        upd_history_o <= ent_hist[head];
      end
      if (mispredict) begin
        redirect_pc_o     <= ent_alt[head];
        restore_history_o <= {ent_hist[head][HISTORY_BITS-2:0], ent_actual[head]};
      end
    end
  end

endmodule

// File: tb/tb_branch_order_ctrl.sv
// Directed bench for branch_order_ctrl (DEPTH=4, HISTORY_BITS=8, RECOVER_CYCLES=2).
module tb_branch_order_ctrl;

  logic        clk_i, reset_n_i;
  logic        issue_valid_i, issue_ready_o, issue_pred_taken_i;
  logic [7:0]  issue_history_i;
  logic [31:0] issue_alt_pc_i;
  logic [1:0]  issue_tag_o;
  logic        res_valid_i, res_ready_o, res_taken_i;
  logic [1:0]  res_tag_i;
  logic        upd_valid_o, upd_taken_o;
  logic [7:0]  upd_history_o;
  logic        flush_o, redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic [7:0]  restore_history_o;
  logic [2:0]  inflight_o;

  int vectors;
  int miscompares;

  branch_order_ctrl #(.DEPTH(4), .HISTORY_BITS(8), .RECOVER_CYCLES(2)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_pred_taken_i(issue_pred_taken_i), .issue_history_i(issue_history_i),
    .issue_alt_pc_i(issue_alt_pc_i), .issue_tag_o(issue_tag_o),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
    .res_tag_i(res_tag_i), .res_taken_i(res_taken_i),
    .upd_valid_o(upd_valid_o), .upd_taken_o(upd_taken_o), .upd_history_o(upd_history_o),
    .flush_o(flush_o), .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .restore_history_o(restore_history_o), .inflight_o(inflight_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    reset_n_i = 1'b0; issue_valid_i = 1'b0; issue_pred_taken_i = 1'b0;
    issue_history_i = '0; issue_alt_pc_i = '0;
    res_valid_i = 1'b0; res_tag_i = '0; res_taken_i = 1'b0;
    #12;
    vectors++;
    if ({issue_ready_o, res_ready_o, upd_valid_o, flush_o, redirect_valid_o} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {issue_ready_o, res_ready_o, upd_valid_o, flush_o, redirect_valid_o});
    end
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    #1;
    vectors++;
    if ({issue_ready_o, res_ready_o, inflight_o, issue_tag_o} !== {2'b11, 3'd0, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_release: ready=%b%b inflight=%0d tag=%0d expected 11 0 0",
               issue_ready_o, res_ready_o, inflight_o, issue_tag_o);
    end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 4; i++) begin
      issue_valid_i = 1'b1; issue_pred_taken_i = 1'b1;
      issue_history_i = 8'(i); issue_alt_pc_i = 32'(i);
      #1;
      vectors++;
      if (issue_tag_o !== 2'(i) || issue_ready_o !== 1'b1) begin
        miscompares++;
        $display("FAIL fill_tag%0d: tag=%0d ready=%b expected tag %0d ready 1",
                 i, issue_tag_o, issue_ready_o, i);
      end
      tick();
    end
    issue_valid_i = 1'b0;
    vectors++;
    if (issue_ready_o !== 1'b0 || inflight_o !== 3'd4) begin
      miscompares++;
      $display("FAIL fill_full: ready=%b inflight=%0d expected 0 4", issue_ready_o, inflight_o);
    end
  endtask

  task automatic test_out_of_order;
    res_valid_i = 1'b1; res_taken_i = 1'b1; res_tag_i = 2'd2;
    tick();
    res_tag_i = 2'd0;
    tick();
    vectors++;
    if (upd_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL ooo_no_same_cycle: upd_valid=%b expected 0", upd_valid_o);
    end
    res_tag_i = 2'd1;
    tick();
    res_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (upd_valid_o !== 1'b1 || upd_history_o !== 8'(i) || upd_taken_o !== 1'b1 || flush_o !== 1'b0) begin
        miscompares++;
        $display("FAIL ooo_retire%0d: v=%b hist=%0h taken=%b flush=%b expected 1 %0h 1 0",
                 i, upd_valid_o, upd_history_o, upd_taken_o, flush_o, i);
      end
      tick();
    end
    vectors++;
    if (upd_valid_o !== 1'b0 || inflight_o !== 3'd1) begin
      miscompares++;
      $display("FAIL ooo_drain: v=%b inflight=%0d expected 0 1", upd_valid_o, inflight_o);
    end
    res_valid_i = 1'b1; res_tag_i = 2'd3;
    tick();
    res_valid_i = 1'b0;
    tick();
    vectors++;
    if (upd_valid_o !== 1'b1 || upd_history_o !== 8'h03 || inflight_o !== 3'd0) begin
      miscompares++;
      $display("FAIL ooo_last: v=%b hist=%0h inflight=%0d expected 1 3 0",
               upd_valid_o, upd_history_o, inflight_o);
    end
  endtask

  task automatic test_mispredict;
    issue_valid_i = 1'b1; issue_pred_taken_i = 1'b1;
    issue_history_i = 8'h5A; issue_alt_pc_i = 32'h0000_1004;
    #1;
    vectors++;
    if (issue_tag_o !== 2'd0) begin
      miscompares++;
      $display("FAIL mp_tag: got %0d expected 0", issue_tag_o);
    end
    tick();
    issue_valid_i = 1'b0;
    res_valid_i = 1'b1; res_tag_i = 2'd0; res_taken_i = 1'b0;
    tick();
    res_valid_i = 1'b0;
    tick();
    vectors++;
    if ({flush_o, redirect_valid_o, upd_valid_o, upd_taken_o} !== 4'b1110 ||
        redirect_pc_o !== 32'h0000_1004 || restore_history_o !== 8'hB4 || inflight_o !== 3'd0) begin
      miscompares++;
      $display("FAIL mp_pulse: fl/rv/uv/ut=%b pc=%h rh=%h infl=%0d expected 1110 1004 b4 0",
               {flush_o, redirect_valid_o, upd_valid_o, upd_taken_o},
               redirect_pc_o, restore_history_o, inflight_o);
    end
    vectors++;
    if (issue_ready_o !== 1'b0 || res_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL mp_ready_low1: %b%b expected 00", issue_ready_o, res_ready_o);
    end
    tick();
    vectors++;
    if (issue_ready_o !== 1'b0 || flush_o !== 1'b0 || redirect_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL mp_ready_low2: ready=%b flush=%b redir=%b expected 0 0 0",
               issue_ready_o, flush_o, redirect_valid_o);
    end
    tick();
    vectors++;
    if (issue_ready_o !== 1'b1 || res_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL mp_resume: %b%b expected 11", issue_ready_o, res_ready_o);
    end
  endtask

  task automatic test_mispredict_flushes_younger;
    int upd_seen;
    upd_seen = 0;
    for (int i = 0; i < 3; i++) begin
      issue_valid_i = 1'b1; issue_pred_taken_i = 1'b1;
      issue_history_i = 8'h10 + 8'(i); issue_alt_pc_i = 32'h2000 + 32'(4 * i);
      tick();
    end
    issue_valid_i = 1'b0;
    res_valid_i = 1'b1; res_taken_i = 1'b1; res_tag_i = 2'd1;
    tick();
    res_tag_i = 2'd2;
    tick();
    res_tag_i = 2'd0; res_taken_i = 1'b0;
    tick();
    res_valid_i = 1'b0;
    issue_valid_i = 1'b1; issue_history_i = 8'hEE;
    tick();
    issue_valid_i = 1'b0;
    vectors++;
    if (flush_o !== 1'b1 || redirect_pc_o !== 32'h2000 || restore_history_o !== 8'h20 || inflight_o !== 3'd0) begin
      miscompares++;
      $display("FAIL young_flush: flush=%b pc=%h rh=%h infl=%0d expected 1 2000 20 0",
               flush_o, redirect_pc_o, restore_history_o, inflight_o);
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      if (upd_valid_o) upd_seen++;
    end
    vectors++;
    if (upd_seen !== 0) begin
      miscompares++;
      $display("FAIL young_no_upd: %0d pulses expected 0", upd_seen);
    end
    vectors++;
    if (issue_tag_o !== 2'd0 || inflight_o !== 3'd0 || issue_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL young_tail: tag=%0d infl=%0d ready=%b expected 0 0 1",
               issue_tag_o, inflight_o, issue_ready_o);
    end
  endtask

  task automatic test_full_retire_wrap;
    for (int i = 0; i < 4; i++) begin
      issue_valid_i = 1'b1; issue_pred_taken_i = 1'b1;
      issue_history_i = 8'h20 + 8'(i); issue_alt_pc_i = 32'h3000 + 32'(i);
      tick();
    end
    res_valid_i = 1'b1; res_tag_i = 2'd0; res_taken_i = 1'b1;
    issue_valid_i = 1'b0;
    tick();
    res_valid_i = 1'b0;
    issue_valid_i = 1'b1; issue_history_i = 8'h77;
    #1;
    vectors++;
    if (issue_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_refuse: ready=%b expected 0", issue_ready_o);
    end
    tick();
    vectors++;
    if (upd_valid_o !== 1'b1 || upd_history_o !== 8'h20 || inflight_o !== 3'd3 ||
        issue_ready_o !== 1'b1 || issue_tag_o !== 2'd0) begin
      miscompares++;
      $display("FAIL wrap_retire: uv=%b hist=%h infl=%0d ready=%b tag=%0d expected 1 20 3 1 0",
               upd_valid_o, upd_history_o, inflight_o, issue_ready_o, issue_tag_o);
    end
    tick();
    issue_valid_i = 1'b0;
    vectors++;
    if (inflight_o !== 3'd4 || issue_tag_o !== 2'd1) begin
      miscompares++;
      $display("FAIL wrap_accept: infl=%0d tag=%0d expected 4 1", inflight_o, issue_tag_o);
    end
  endtask

  task automatic test_async_reset;
    res_valid_i = 1'b1; res_tag_i = 2'd1; res_taken_i = 1'b0;
    tick();
    res_valid_i = 1'b0;
    tick();
    vectors++;
    if (flush_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre_pulse: flush=%b expected 1", flush_o);
    end
    #2 reset_n_i = 1'b0;
    #1;
    vectors++;
    if ({flush_o, redirect_valid_o, upd_valid_o, upd_taken_o, issue_ready_o, res_ready_o} !== 6'b0 ||
        redirect_pc_o !== 32'd0 || restore_history_o !== 8'd0 || upd_history_o !== 8'd0 ||
        inflight_o !== 3'd0 || issue_tag_o !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_mid_pulse: ctl=%b pc=%h rh=%h uh=%h infl=%0d tag=%0d expected all 0",
               {flush_o, redirect_valid_o, upd_valid_o, upd_taken_o, issue_ready_o, res_ready_o},
               redirect_pc_o, restore_history_o, upd_history_o, inflight_o, issue_tag_o);
    end
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    #1;
    vectors++;
    if (issue_ready_o !== 1'b1 || res_ready_o !== 1'b1 || inflight_o !== 3'd0) begin
      miscompares++;
      $display("FAIL rst_release1: %b%b infl=%0d expected 11 0", issue_ready_o, res_ready_o, inflight_o);
    end
    issue_valid_i = 1'b1; issue_pred_taken_i = 1'b0; issue_history_i = 8'h03;
    tick();
    issue_valid_i = 1'b0;
    res_valid_i = 1'b1; res_tag_i = 2'd0; res_taken_i = 1'b1;
    tick();
    res_valid_i = 1'b0;
    tick();
    tick();
    vectors++;
    if (issue_ready_o !== 1'b0 || flush_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_in_recover: ready=%b flush=%b expected 0 0", issue_ready_o, flush_o);
    end
    #2 reset_n_i = 1'b0;
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    #1;
    vectors++;
    if (issue_ready_o !== 1'b1 || inflight_o !== 3'd0 || issue_tag_o !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_release2: ready=%b infl=%0d tag=%0d expected 1 0 0",
               issue_ready_o, inflight_o, issue_tag_o);
    end
    issue_valid_i = 1'b1; issue_pred_taken_i = 1'b1; issue_history_i = 8'h44;
    tick();
    issue_valid_i = 1'b0;
    res_valid_i = 1'b1; res_tag_i = 2'd0; res_taken_i = 1'b1;
    tick();
    res_valid_i = 1'b0;
    tick();
    vectors++;
    if (upd_valid_o !== 1'b1 || upd_history_o !== 8'h44 || flush_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_after_retire: uv=%b hist=%h flush=%b expected 1 44 0",
               upd_valid_o, upd_history_o, flush_o);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_fill();
    test_out_of_order();
    test_mispredict();
    test_mispredict_flushes_younger();
    test_full_retire_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
